xoodyak_digest_collector: RTL and testbench

- Downstream of the XOODYAK hash core; consumes its byte-serial `hash`/`valid` stream.
- Assembles DIGEST_BYTES bytes into one digest word.
- Presents the digest on a valid/ready interface to the system bus side.
- Double-buffered so the non-stallable core never needs backpressure; detects overrun and stalled-stream timeout.

---
 rtl/xoodyak_pkg.sv | 8 +
 rtl/xoodyak_digest_collector_if.sv | 11 +
 rtl/xoodyak_gap_timer.sv | 21 ++
 rtl/xoodyak_digest_collector.sv | 109 ++++++++++
 tb/tb_xoodyak_digest_collector.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/xoodyak_pkg.sv
// Shared XOODYAK constants and the digest-collector FSM encoding.
package xoodyak_pkg;
  localparam int BYTE_W           = 8;
  localparam int DEF_DIGEST_BYTES = 32;
  localparam int DEF_TIMEOUT      = 64;

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;
endpackage

// File: rtl/xoodyak_digest_collector_if.sv
// Digest output handshake toward the system bus: valid/ready plus the digest word.
interface xoodyak_digest_collector_if
  import xoodyak_pkg::*;
#(parameter int DIGEST_BYTES = DEF_DIGEST_BYTES);
  logic [BYTE_W*DIGEST_BYTES-1:0] digest;
  logic                           digest_valid;
  logic                           digest_ready;

  modport master (output digest, digest_valid, input digest_ready);
  modport slave  (input digest, digest_valid, output digest_ready);
endinterface

// File: rtl/xoodyak_gap_timer.sv
// 8-bit saturating idle counter; expired flags the idle cycle that reaches TIMEOUT.
module xoodyak_gap_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           cnt <= '0;
    else if (clr)                          cnt <= '0;
    else if (en && (cnt < 8'(TIMEOUT)))    cnt <= cnt + 8'd1;
  end

  // This idle cycle is the TIMEOUT-th one in a row.
  assign expired = en && (({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT));
endmodule

// File: rtl/xoodyak_digest_collector.sv
// Byte-serial hash stream to double-buffered digest word with overrun/timeout detection.
// Optional compare-against-expected port set enabled by DIGEST_COMPARE_EN.
module xoodyak_digest_collector
  import xoodyak_pkg::*;
#(
  parameter int DIGEST_BYTES = DEF_DIGEST_BYTES,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  localparam int CW          = $clog2(DIGEST_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  abort,
  input  logic [BYTE_W-1:0]     in_byte,
  input  logic                  in_valid,
  xoodyak_digest_collector_if.master bus,
  output logic [CW-1:0]         byte_cnt,
  output logic                  err_overrun,
  output logic                  err_timeout,
  input  logic                  err_clr
`ifdef DIGEST_COMPARE_EN
  ,
  input  logic [BYTE_W*DIGEST_BYTES-1:0] expected,
  output logic                           match
`endif
);
  state_t                         state;
  logic [BYTE_W*DIGEST_BYTES-1:0] asm_q, digest_q;
  logic                           dvalid_q;
  logic                           expired, drain;

  assign bus.digest       = digest_q;
  assign bus.digest_valid = dvalid_q;
  assign drain            = dvalid_q && bus.digest_ready;

  xoodyak_gap_timer #(.TIMEOUT(TIMEOUT)) u_gap (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (abort || in_valid || (state != COLLECT)),
    .en      ((state == COLLECT) && !in_valid),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      asm_q       <= '0;
      digest_q    <= '0;
      dvalid_q    <= 1'b0;
      byte_cnt    <= '0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
`ifdef DIGEST_COMPARE_EN
      match       <= 1'b0;
`endif
    end else begin
      // Later assignments (refill, new error events) override these.
      if (drain)   dvalid_q <= 1'b0;
      if (err_clr) begin
        err_overrun <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (abort) begin
        state    <= IDLE;
        asm_q    <= '0;
        byte_cnt <= '0;
`ifdef DIGEST_COMPARE_EN
        match    <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            asm_q[BYTE_W-1:0] <= in_byte;
            byte_cnt          <= CW'(1);
            state             <= COLLECT;
          end
          COLLECT: begin
            if (in_valid) begin
              asm_q[BYTE_W*int'(byte_cnt) +: BYTE_W] <= in_byte;
              byte_cnt <= byte_cnt + CW'(1);
              if (byte_cnt == CW'(DIGEST_BYTES - 1)) state <= COMMIT;
            end else if (expired) begin
              err_timeout <= 1'b1;
              asm_q       <= '0;
              byte_cnt    <= '0;
              state       <= IDLE;
            end
          end
          COMMIT: begin
            if (!dvalid_q || drain) begin
              digest_q <= asm_q;
              dvalid_q <= 1'b1;
            end else begin
              err_overrun <= 1'b1;
            end
            // A byte arriving here has nowhere to go.
            if (in_valid) err_overrun <= 1'b1;
`ifdef DIGEST_COMPARE_EN
            match    <= (asm_q == expected);
`endif
            asm_q    <= '0;
            byte_cnt <= '0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_xoodyak_digest_collector.sv
// Directed bench for xoodyak_digest_collector (default build, 32-byte digest, TIMEOUT 64).
module tb_xoodyak_digest_collector;
  localparam int DB = 32;
  localparam int DW = 8 * DB;

  logic          clk = 1'b0;
  logic          resetn;
  logic          abort;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic [5:0]    byte_cnt;
  logic          err_overrun, err_timeout, err_clr;
  int            vectors = 0;
  int            miscompares = 0;

  xoodyak_digest_collector_if #(.DIGEST_BYTES(DB)) bus ();

  xoodyak_digest_collector #(.DIGEST_BYTES(DB), .TIMEOUT(64)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .abort       (abort),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .bus         (bus),
    .byte_cnt    (byte_cnt),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed_const(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_byte  = b;
      tick();
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic feed_inc(input int n, input logic [7:0] start);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_byte  = start + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {DB{b}};
  endfunction

  function automatic logic [DW-1:0] inc(input logic [7:0] start);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DB; i++) v[8*i +: 8] = start + 8'(i);
    return v;
  endfunction

  initial begin
    logic [DW-1:0] d;
    resetn = 1'b0; abort = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
    err_clr = 1'b0; bus.digest_ready = 1'b1;
    #22;
    chk("reset_digest", bus.digest, '0);
    chk("reset_valid",  DW'(bus.digest_valid), '0);
    chk("reset_cnt",    DW'(byte_cnt), '0);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();

    // Normal digest, consumer always ready
    feed_inc(32, 8'h00);
    chk("norm_cnt_commit", DW'(byte_cnt), DW'(32));
    chk("norm_valid_n1",   DW'(bus.digest_valid), '0);
    tick();
    chk("norm_valid_n2",   DW'(bus.digest_valid), DW'(1));
    d = bus.digest;
    chk("norm_byte0",      DW'(d[7:0]), DW'(8'h00));
    chk("norm_byte31",     DW'(d[255:248]), DW'(8'h1F));
    chk("norm_digest",     bus.digest, inc(8'h00));
    chk("norm_cnt_idle",   DW'(byte_cnt), '0);
    tick();
    chk("norm_valid_drop", DW'(bus.digest_valid), '0);
    chk("norm_errs",       DW'({err_overrun, err_timeout}), '0);

    // Backpressure and overrun
    bus.digest_ready = 1'b0;
    feed_const(32, 8'hA5);
    tick();
    chk("bp_valid",   DW'(bus.digest_valid), DW'(1));
    chk("bp_digest",  bus.digest, rep(8'hA5));
    tick(); tick(); tick();
    chk("bp_held",    DW'(bus.digest_valid), DW'(1));
    chk("bp_stable",  bus.digest, rep(8'hA5));
    feed_const(32, 8'h3C);
    tick();
    chk("ovr_flag",   DW'(err_overrun), DW'(1));
    chk("ovr_keep",   bus.digest, rep(8'hA5));
    chk("ovr_valid",  DW'(bus.digest_valid), DW'(1));
    bus.digest_ready = 1'b1;
    tick();
    chk("bp_drop",    DW'(bus.digest_valid), '0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("ovr_clr",    DW'(err_overrun), '0);

    // Timeout after a stalled partial digest
    feed_const(10, 8'h11);
    for (int i = 0; i < 63; i++) tick();
    chk("to_not_yet", DW'(err_timeout), '0);
    chk("to_cnt_hold", DW'(byte_cnt), DW'(10));
    tick();
    chk("to_flag",    DW'(err_timeout), DW'(1));
    chk("to_cnt",     DW'(byte_cnt), '0);
    chk("to_novalid", DW'(bus.digest_valid), '0);
    feed_inc(32, 8'h40);
    tick();
    chk("to_next_valid",  DW'(bus.digest_valid), DW'(1));
    chk("to_next_digest", bus.digest, inc(8'h40));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_clr", DW'({err_overrun, err_timeout}), '0);

    // Abort mid-stream, with a byte offered in the abort cycle
    feed_const(20, 8'h77);
    abort = 1'b1; in_valid = 1'b1; in_byte = 8'hEE;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("ab_cnt", DW'(byte_cnt), '0);
    feed_const(32, 8'h55);
    tick();
    chk("ab_valid",  DW'(bus.digest_valid), DW'(1));
    chk("ab_digest", bus.digest, rep(8'h55));
    chk("ab_errs",   DW'({err_overrun, err_timeout}), '0);
    tick();

    // Consumer drains in exactly the COMMIT cycle of the next digest
    bus.digest_ready = 1'b0;
    feed_const(32, 8'h9A);
    tick();
    chk("rf_first", bus.digest, rep(8'h9A));
    tick();
    feed_const(32, 8'hC3);
    bus.digest_ready = 1'b1;
    tick();
    chk("rf_valid",   DW'(bus.digest_valid), DW'(1));
    chk("rf_digest",  bus.digest, rep(8'hC3));
    chk("rf_overrun", DW'(err_overrun), '0);
    tick();
    chk("rf_drop",    DW'(bus.digest_valid), '0);

    // Asynchronous reset in the middle of a digest
    feed_const(7, 8'h21);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_cnt",    DW'(byte_cnt), '0);
    chk("ar_digest", bus.digest, '0);
    chk("ar_valid",  DW'(bus.digest_valid), '0);
    chk("ar_errs",   DW'({err_overrun, err_timeout}), '0);
    tick();
    resetn = 1'b1;
    tick();
    feed_inc(32, 8'hE0);
    tick();
    chk("ar_next_valid",  DW'(bus.digest_valid), DW'(1));
    chk("ar_next_digest", bus.digest, inc(8'hE0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
